pixel_fetch: RTL and testbench

//  Downstream consumer of the pixel-map address FIFO. Pops {valid,addr[18:0]} words, issues

---
 rtl/pixel_fetch_if.sv | 23 ++
 rtl/pixel_fetch.sv | 78 +++++++
 tb/tb_pixel_fetch.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fetch_if.sv
// Bus bundle for pixel_fetch: upstream address FIFO, frame-buffer SRAM read port and display pop side.
// The slave modport is the fetch block's view; master is the surrounding system's.
interface pixel_fetch_if;
    logic [19:0] address;
    logic        ready_n;
    logic        read;
    logic [18:0] sram_addr;
    logic        sram_rd;
    logic [15:0] sram_data;
    logic        disp_req;
    logic [15:0] pixel;
    logic        underflow;
    logic [15:0] uflow_count;

    modport master (
        output address, ready_n, sram_data, disp_req,
        input  read, sram_addr, sram_rd, pixel, underflow, uflow_count
    );
    modport slave (
        input  address, ready_n, sram_data, disp_req,
        output read, sram_addr, sram_rd, pixel, underflow, uflow_count
    );
endinterface

// File: rtl/pixel_fetch.sv
// Pops pixel addresses, reads the frame buffer (or substitutes blank for off-screen slots)
// and queues pixels in a credit-protected output FIFO drained one per display request.
module pixel_fetch #(
    parameter int          SRAM_LATENCY = 2,
    parameter int          OUT_DEPTH    = 8,
    parameter logic [15:0] BLANK_COLOUR = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    pixel_fetch_if.slave bus
);
    localparam int PW = $clog2(OUT_DEPTH);

    logic [PW:0]             credits;
    logic [PW:0]             wr_ptr;
    logic [PW:0]             rd_ptr;
    logic [15:0]             mem [OUT_DEPTH];
    logic [SRAM_LATENCY:0]   vld_pipe;
    logic [SRAM_LATENCY:1]   av_pipe;
    logic [18:0]             addr_q;
    logic                    issue;
    logic                    hit;
    logic                    empty;
    logic                    pop;
    logic                    wr_en;
    logic [15:0]             wr_data;

    // A credit covers every slot from pop until the display drains it, so the FIFO cannot overflow.
    assign issue = rst_n && !bus.ready_n && (credits < (PW+1)'(OUT_DEPTH));
    assign bus.read = issue;

    // vld_pipe[0] marks the cycle the popped word is on the upstream q.
    assign hit           = vld_pipe[0] && bus.address[19];
    assign bus.sram_rd   = hit;
    assign bus.sram_addr = hit ? bus.address[18:0] : addr_q;

    assign wr_en   = vld_pipe[SRAM_LATENCY];
    assign wr_data = av_pipe[SRAM_LATENCY] ? bus.sram_data : BLANK_COLOUR;

    // Empty is from registered pointers only: a write landing this cycle cannot serve a pop.
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = bus.disp_req && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[PW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            vld_pipe        <= '0;
            av_pipe         <= '0;
            addr_q          <= '0;
            bus.pixel       <= BLANK_COLOUR;
            bus.underflow   <= 1'b0;
            bus.uflow_count <= '0;
        end else begin
            credits  <= credits + (PW+1)'(issue) - (PW+1)'(pop);
            vld_pipe <= {vld_pipe[SRAM_LATENCY-1:0], issue};
            for (int k = SRAM_LATENCY; k > 1; k--) av_pipe[k] <= av_pipe[k-1];
            av_pipe[1] <= bus.address[19];
            addr_q     <= bus.sram_addr;
            if (wr_en) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (bus.disp_req) begin
                if (!empty) begin
                    bus.pixel <= mem[rd_ptr[PW-1:0]];
                    rd_ptr    <= rd_ptr + (PW+1)'(1);
                end else begin
                    bus.pixel     <= BLANK_COLOUR;
                    bus.underflow <= 1'b1;
                    if (bus.uflow_count != 16'hFFFF) bus.uflow_count <= bus.uflow_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: upstream FIFO and SRAM models, scoreboard of expected pixels,
// plus two extra instances at SRAM latencies 1 and 4 for exact write timing.
module tb_pixel_fetch;
    localparam logic [15:0] BLANK = 16'h0000;
    localparam int          DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_fetch_if bus ();
    pixel_fetch_if if1 ();
    pixel_fetch_if if4 ();

    pixel_fetch #(.SRAM_LATENCY(2), .OUT_DEPTH(DEPTH), .BLANK_COLOUR(BLANK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    pixel_fetch #(.SRAM_LATENCY(1), .OUT_DEPTH(DEPTH), .BLANK_COLOUR(BLANK)) u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    pixel_fetch #(.SRAM_LATENCY(4), .OUT_DEPTH(DEPTH), .BLANK_COLOUR(BLANK)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4));

    int          checks = 0;
    int          failures = 0;
    int          rd_cnt = 0;
    int          cred_viol = 0;
    logic        hold = 1'b1;
    logic        chk_en = 1'b0;
    logic        cred_mon = 1'b0;
    logic        req_seen = 1'b0;
    logic [15:0] sb_exp;
    logic [19:0] up_q [$];
    logic [15:0] exp_q [$];
    logic [18:0] rd_addrs [$];

    // Upstream normal-mode FIFO: q changes on the edge that samples rdreq.
    always @(posedge clk) begin
        if (bus.read && up_q.size() > 0) bus.address <= up_q.pop_front();
        bus.ready_n <= hold || (up_q.size() == 0);
        if (bus.read) rd_cnt = rd_cnt + 1;
        if (bus.sram_rd) rd_addrs.push_back(bus.sram_addr);
        req_seen = bus.disp_req && rst_n;
    end

    // SRAM models: data = addr+0x100 exactly LAT cycles after the strobe, garbage otherwise.
    logic [15:0] sp1;
    logic [15:0] sp2 [2];
    logic [15:0] sp4 [4];
    always @(posedge clk) begin
        sp1    <= if1.sram_rd ? if1.sram_addr[15:0] + 16'h100 : 16'hDEAD;
        sp2[0] <= bus.sram_rd ? bus.sram_addr[15:0] + 16'h100 : 16'hDEAD;
        sp2[1] <= sp2[0];
        sp4[0] <= if4.sram_rd ? if4.sram_addr[15:0] + 16'h100 : 16'hDEAD;
        for (int k = 1; k < 4; k++) sp4[k] <= sp4[k-1];
    end
    assign if1.sram_data = sp1;
    assign bus.sram_data = sp2[1];
    assign if4.sram_data = sp4[3];

    always @(negedge clk) begin
        if (cred_mon && dut.credits > DEPTH) cred_viol = cred_viol + 1;
        if (chk_en && req_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty pixel=%h", bus.pixel);
            end else begin
                sb_exp = exp_q.pop_front();
                if (bus.pixel !== sb_exp) begin
                    failures++;
                    $display("FAIL pixel_order got=%h exp=%h", bus.pixel, sb_exp);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [19:0] a);
        up_q.push_back(a);
        exp_q.push_back(a[19] ? a[15:0] + 16'h100 : BLANK);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            bus.disp_req = 1'b1;
            cycles(1);
            bus.disp_req = 1'b0;
            cycles(4);
        end
    endtask

    task automatic do_reset();
        hold = 1'b1;
        chk_en = 1'b0;
        bus.disp_req = 1'b0;
        rst_n = 1'b0;
        up_q.delete();
        exp_q.delete();
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_reset();
        cycles(2);
        checks++;
        if (bus.read !== 1'b0 || bus.sram_rd !== 1'b0 || bus.sram_addr !== 19'h0) begin
            failures++;
            $display("FAIL reset_bus read=%b sram_rd=%b sram_addr=%h exp 0/0/0", bus.read, bus.sram_rd, bus.sram_addr);
        end
        checks++;
        if (bus.pixel !== BLANK || bus.underflow !== 1'b0 || bus.uflow_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_disp pixel=%h uflow=%b cnt=%0d exp blank/0/0", bus.pixel, bus.underflow, bus.uflow_count);
        end
        rst_n = 1'b1;
        hold = 1'b0;
        for (int i = 0; i < 8; i++) push({1'b1, 19'(32'h10 + i)});
        cycles(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.read !== 1'b0 || bus.sram_rd !== 1'b0 || bus.sram_addr !== 19'h0) begin
            failures++;
            $display("FAIL reset_midburst read=%b sram_rd=%b sram_addr=%h exp 0/0/0", bus.read, bus.sram_rd, bus.sram_addr);
        end
        hold = 1'b1;
        up_q.delete();
        exp_q.delete();
        cycles(3);
        rst_n = 1'b1;
        cycles(8);
        bus.disp_req = 1'b1;
        cycles(1);
        bus.disp_req = 1'b0;
        checks++;
        if (bus.underflow !== 1'b1 || bus.uflow_count !== 16'd1 || bus.pixel !== BLANK) begin
            failures++;
            $display("FAIL reset_no_stale_write uflow=%b cnt=%0d pixel=%h exp 1/1/blank", bus.underflow, bus.uflow_count, bus.pixel);
        end
        do_reset();
    endtask

    task automatic test_stream();
        rd_cnt = 0;
        hold = 1'b0;
        for (int i = 0; i < 20; i++) push({1'b1, 19'(i)});
        cycles(40);
        checks++;
        if (rd_cnt != DEPTH || bus.read !== 1'b0) begin
            failures++;
            $display("FAIL stream_credit_stop reads=%0d read=%b exp %0d/0", rd_cnt, bus.read, DEPTH);
        end
        chk_en = 1'b1;
        drain(20);
        chk_en = 1'b0;
        checks++;
        if (exp_q.size() != 0 || rd_cnt != 20 || bus.underflow !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain left=%0d reads=%0d uflow=%b exp 0/20/0", exp_q.size(), rd_cnt, bus.underflow);
        end
    endtask

    task automatic test_invalid();
        rd_addrs.delete();
        push({1'b1, 19'h00040});
        push({1'b0, 19'h12345});
        push({1'b1, 19'h00041});
        cycles(10);
        checks++;
        if (rd_addrs.size() != 2) begin
            failures++;
            $display("FAIL invalid_strobes count=%0d exp 2", rd_addrs.size());
        end else if (rd_addrs[0] !== 19'h40 || rd_addrs[1] !== 19'h41) begin
            failures++;
            $display("FAIL invalid_strobes addrs=%h,%h exp 40,41", rd_addrs[0], rd_addrs[1]);
        end
        chk_en = 1'b1;
        drain(3);
        chk_en = 1'b0;
    endtask

    task automatic test_underflow();
        do_reset();
        hold = 1'b0;
        push({1'b1, 19'h00005});
        cycles(8);
        chk_en = 1'b1;
        drain(1);
        chk_en = 1'b0;
        hold = 1'b1;
        cycles(5);
        checks++;
        if (bus.pixel !== 16'h0105) begin
            failures++;
            $display("FAIL pixel_hold got=%h exp 0105", bus.pixel);
        end
        bus.disp_req = 1'b1;
        cycles(3);
        bus.disp_req = 1'b0;
        cycles(1);
        checks++;
        if (bus.pixel !== BLANK || bus.underflow !== 1'b1 || bus.uflow_count !== 16'd3) begin
            failures++;
            $display("FAIL underflow pixel=%h uflow=%b cnt=%0d exp blank/1/3", bus.pixel, bus.underflow, bus.uflow_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] a;
        do_reset();
        hold = 1'b0;
        cred_viol = 0;
        for (int i = 0; i < 1200; i++) begin
            a = {($urandom_range(0, 7) != 0), 19'($urandom_range(0, 32'h7FFFF))};
            push(a);
        end
        cycles(20);
        chk_en = 1'b1;
        cred_mon = 1'b1;
        bus.disp_req = 1'b1;
        cycles(1100);
        bus.disp_req = 1'b0;
        cycles(2);
        chk_en = 1'b0;
        cred_mon = 1'b0;
        checks++;
        if (bus.underflow !== 1'b0 || bus.uflow_count !== 16'd0) begin
            failures++;
            $display("FAIL steady_underflow uflow=%b cnt=%0d exp 0/0", bus.underflow, bus.uflow_count);
        end
        checks++;
        if (cred_viol != 0) begin
            failures++;
            $display("FAIL credit_bound violations=%0d exp 0", cred_viol);
        end
    endtask

    // Single pop at cycle T; latency L must write at T+1+L, visible to a request only at T+2+L.
    task automatic test_latency();
        do_reset();
        if1.ready_n = 1'b0;
        if4.ready_n = 1'b0;
        #1;
        checks++;
        if (if1.read !== 1'b1 || if4.read !== 1'b1) begin
            failures++;
            $display("FAIL lat_issue read1=%b read4=%b exp 1/1", if1.read, if4.read);
        end
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 1) begin
                if1.ready_n = 1'b1;
                if4.ready_n = 1'b1;
                if1.address = {1'b1, 19'h00077};
                if4.address = {1'b1, 19'h00099};
                #1;
                checks++;
                if (if1.sram_rd !== 1'b1 || if1.sram_addr !== 19'h77 || if4.sram_rd !== 1'b1 || if4.sram_addr !== 19'h99) begin
                    failures++;
                    $display("FAIL lat_sram_rd rd1=%b a1=%h rd4=%b a4=%h exp 1/77/1/99", if1.sram_rd, if1.sram_addr, if4.sram_rd, if4.sram_addr);
                end
            end
            if (j == 3) begin
                checks++;
                if (if1.underflow !== 1'b1 || if1.uflow_count !== 16'd1) begin
                    failures++;
                    $display("FAIL lat1_no_bypass uflow=%b cnt=%0d exp 1/1", if1.underflow, if1.uflow_count);
                end
            end
            if (j == 4) begin
                checks++;
                if (if1.pixel !== 16'h0177 || if1.uflow_count !== 16'd1) begin
                    failures++;
                    $display("FAIL lat1_write pixel=%h cnt=%0d exp 0177/1", if1.pixel, if1.uflow_count);
                end
            end
            if (j == 6) begin
                checks++;
                if (if4.underflow !== 1'b1 || if4.uflow_count !== 16'd1) begin
                    failures++;
                    $display("FAIL lat4_no_bypass uflow=%b cnt=%0d exp 1/1", if4.underflow, if4.uflow_count);
                end
            end
            if (j == 7) begin
                checks++;
                if (if4.pixel !== 16'h0199 || if4.uflow_count !== 16'd1) begin
                    failures++;
                    $display("FAIL lat4_write pixel=%h cnt=%0d exp 0199/1", if4.pixel, if4.uflow_count);
                end
            end
            if1.disp_req = (j == 2 || j == 3);
            if4.disp_req = (j == 5 || j == 6);
        end
        @(negedge clk);
        if1.disp_req = 1'b0;
        if4.disp_req = 1'b0;
    endtask

    initial begin
        bus.disp_req = 1'b0;
        if1.ready_n = 1'b1;
        if4.ready_n = 1'b1;
        if1.disp_req = 1'b0;
        if4.disp_req = 1'b0;
        if1.address = '0;
        if4.address = '0;
        test_reset();
        test_stream();
        test_invalid();
        test_underflow();
        test_back_to_back();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
